alu_sequencer: RTL

- Multi-cycle controller that sequences the 16-bit ALU for one decoded instruction at a time.
- Accepts an instruction from the decoder over a valid/ready handshake and reads operands from the single-read-port register file.
- Drives the ALU's value1/value2/operator/single inputs, captures the ALU's registered bus_out and writes it back.
- Evaluates branches through the ALU's combinational check_branch.
- Sits between the decoder and the ALU/register file in the CPU core.

---
 rtl/alu_sequencer_if.sv | 23 ++
 rtl/alu_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake between the decoder (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
  parameter int REG_AW = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_kind;
  logic [3:0]        instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_rs;
  logic              instr_use_imm;
  logic [15:0]       instr_imm;

  modport master (
    output instr_valid, instr_kind, instr_op, instr_rd, instr_rs, instr_use_imm, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_kind, instr_op, instr_rd, instr_rs, instr_use_imm, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving the 16-bit ALU and register file for one instruction at a time.
// Optional macro ALU_SEQ_PIPE_EN: accept the next instruction in WB/BRANCH (no IDLE bubble).
module alu_sequencer #(
  parameter int         REG_AW  = 3,
  parameter logic [3:0] HOLD_OP = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    dec,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [15:0]       rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic [15:0]       alu_value1,
  output logic [15:0]       alu_value2,
  output logic [3:0]        alu_operator,
  output logic              alu_single,
  input  logic [15:0]       alu_bus_out,
  input  logic              alu_check_branch,
  output logic              done,
  output logic              branch_taken,
  output logic              illegal
);

  // Operator codes shared with cpu_data.v
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_RJMP = 4'hF;

  localparam logic [1:0] KIND_BIN = 2'd0;
  localparam logic [1:0] KIND_SGL = 2'd1;
  localparam logic [1:0] KIND_BR  = 2'd2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ_A = 3'd1;
  localparam logic [2:0] READ_B = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] BRANCH = 3'd5;

  logic [2:0]        state, state_nx;
  logic              ready, accept;
  logic [1:0]        kind_p0;
  logic [3:0]        op_p0;
  logic [REG_AW-1:0] rd_p0, rs_p0;
  logic              use_imm_p0;
  logic [15:0]       imm_p0;
  logic [15:0]       op_a_p1, op_b_p1;
  logic              ill_vld_p0;

`ifdef ALU_SEQ_PIPE_EN
  assign ready = (state == IDLE) || (state == WB) || (state == BRANCH);
`else
  assign ready = (state == IDLE);
`endif

  assign dec.instr_ready = ready;
  assign accept          = dec.instr_valid && ready;

  always_comb begin
    state_nx = state;
    case (state)
      READ_A:  state_nx = (kind_p0 == KIND_BIN && !use_imm_p0) ? READ_B : EXEC;
      READ_B:  state_nx = EXEC;
      EXEC:    state_nx = WB;
      default: state_nx = IDLE;
    endcase
    // An acceptance overrides the default return to IDLE
    if (accept) begin
      case (dec.instr_kind)
        KIND_BIN, KIND_SGL: state_nx = READ_A;
        KIND_BR:            state_nx = BRANCH;
        default:            state_nx = IDLE;
      endcase
    end
  end

  // Stage p0: instruction capture; stage p1: operand fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ill_vld_p0 <= 1'b0;
      kind_p0    <= '0;
      op_p0      <= '0;
      rd_p0      <= '0;
      rs_p0      <= '0;
      use_imm_p0 <= 1'b0;
      imm_p0     <= '0;
      op_a_p1    <= '0;
      op_b_p1    <= '0;
    end else begin
      state      <= state_nx;
      ill_vld_p0 <= accept && (dec.instr_kind == 2'd3);
      if (accept) begin
        kind_p0    <= dec.instr_kind;
        op_p0      <= dec.instr_op;
        rd_p0      <= dec.instr_rd;
        rs_p0      <= dec.instr_rs;
        use_imm_p0 <= dec.instr_use_imm;
        imm_p0     <= dec.instr_imm;
      end
      case (state)
        READ_A: begin
          op_a_p1 <= rf_rdata;
          op_b_p1 <= (kind_p0 == KIND_BIN && use_imm_p0) ? imm_p0 : 16'h0000;
        end
        READ_B:  op_b_p1 <= rf_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_value1   = '0;
    alu_value2   = '0;
    alu_operator = HOLD_OP;
    alu_single   = 1'b1;
    rf_we        = 1'b0;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    rf_raddr     = (state == READ_B) ? rs_p0 : rd_p0;
    rf_waddr     = rd_p0;
    rf_wdata     = alu_bus_out;
    case (state)
      EXEC: begin
        alu_value1   = op_a_p1;
        alu_value2   = (kind_p0 == KIND_SGL) ? 16'h0000 : op_b_p1;
        alu_operator = op_p0;
        alu_single   = (kind_p0 == KIND_SGL);
      end
      WB: begin
        rf_we = (op_p0 != OP_CMP);
        done  = 1'b1;
      end
      BRANCH: begin
        alu_operator = op_p0;
        done         = 1'b1;
        // Flags are still the pre-edge ones here; RJMP ignores them
        branch_taken = (op_p0 == OP_RJMP) || alu_check_branch;
      end
      default: ;
    endcase
    if (ill_vld_p0) begin
      done    = 1'b1;
      illegal = 1'b1;
    end
    if (reset) begin
      rf_we        = 1'b0;
      done         = 1'b0;
      branch_taken = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule
